softex_tcdm_sched: RTL
======================

// Module: softex_tcdm_sched
// PURPOSE
//  Schedules N_REQ streamer sources (in-stream load, out-stream store, slot load, slot store) onto one TCDM port.
//  - Round-robin with bounded burst lock; each owner keeps the port for up to MAX_BURST beats.
//  - Routes read responses back to the issuing source via an in-order ID FIFO.
//  - Sits between the SoftEx streamer sources and the HCI initiator port.
// PARAMETERS
//  N_REQ      4   number of requesters; index 0 = highest reset priority
//  ADDR_W     32  TCDM address width
//  DATA_W     128 TCDM data width; BE width = DATA_W/8
//  MAX_BURST  8   max consecutive granted beats per owner before forced rotation (>=1)
//  MAX_OUTST  4   max outstanding reads (ID FIFO depth, power of 2)
// PORTS
//  clk_i          in   1                 clock
//  rst_i          in   1                 synchronous reset, active-high
//  clear_i        in   1                 synchronous soft clear, same effect as rst_i
//  req_i          in   N_REQ             per-source request
//  we_i           in   N_REQ             per-source write enable (1 = store)
//  addr_i         in   N_REQ*ADDR_W      per-source address
//  wdata_i        in   N_REQ*DATA_W      per-source write data
//  be_i           in   N_REQ*DATA_W/8    per-source byte enables
//  gnt_o          out  N_REQ             per-source grant, one-hot or zero
//  rvalid_o       out  N_REQ             per-source read-data valid, one-hot or zero
//  rdata_o        out  DATA_W            read data, broadcast to all sources
//  tcdm_req_o     out  1                 TCDM request
//  tcdm_gnt_i     in   1                 TCDM grant
//  tcdm_we_o      out  1                 TCDM write enable
//  tcdm_add_o     out  ADDR_W            TCDM address
//  tcdm_data_o    out  DATA_W            TCDM write data
//  tcdm_be_o      out  DATA_W/8          TCDM byte enables
//  tcdm_r_valid_i in   1                 TCDM read response valid
//  tcdm_r_data_i  in   DATA_W            TCDM read response data
//  owner_o        out  $clog2(N_REQ)     current owner index
//  busy_o         out  1                 any request pending or read outstanding
// BEHAVIOUR
//  Reset / clear:
//  - FSM in IDLE; owner_o=0; RR pointer=0; beat count=0; ID FIFO empty; busy_o=0.
//  - All gnt_o, rvalid_o, tcdm_req_o = 0; rdata_o passes tcdm_r_data_i.
//  FSM states:
//  - IDLE: select first requesting source at or after RR pointer (wrap modulo N_REQ); latch owner; -> OWN the same cycle.
//    Selection is combinational, so a request in IDLE can be issued with zero added latency.
//  - OWN: drive tcdm_* from owner's inputs; tcdm_req_o = req_i[owner] & ~rd_block.
//    rd_block = ~we_i[owner] & ID FIFO full. Writes are never blocked by a full FIFO.
//  Handshake:
//  - gnt_o[owner] = tcdm_gnt_i & tcdm_req_o; a beat completes on that cycle and beat count increments.
//  - Read beat: push owner index into ID FIFO.
//  - tcdm_r_valid_i: pop FIFO head h; rvalid_o[h]=1 in the same cycle (combinational response path).
//  - Same-cycle push and pop allowed, including when the FIFO is full.
//  - tcdm_r_valid_i with an empty FIFO is a protocol error: ignored, no rvalid_o (assert in sim).
//  Rotation (owner releases, RR pointer = owner+1 mod N_REQ, beat count=0, -> IDLE):
//  - req_i[owner] drops while not granted, or
//  - beat count reaches MAX_BURST on a completed beat.
//  Release takes effect next cycle, so one idle cycle per owner switch.
//  Other rules:
//  - A source must hold req_i and its payload stable until gnt_o; dropping req_i without a grant is legal.
//  - An owner with a blocked read (FIFO full) keeps ownership; no skipping.
//  - busy_o = |req_i | ~fifo_empty.
//  - clear_i mid-operation discards outstanding IDs; responses arriving afterwards hit the empty-FIFO rule.
// CONFIGURATION
//  SOFTEX_TCDM_SCHED_PERF_EN defined:
//  - Adds output perf_o (N_REQ*2*32): per source, a granted-beat counter and a stall counter.
//  - Stall counter increments on req_i=1 & gnt_o=0.
//  - Counters are 32b saturating and zeroed by rst_i/clear_i.
//  Macro undefined: port, counters and logic are absent; behaviour otherwise identical.
// TESTING
//  1. Src0 req 20 writes, gnt_i always 1, MAX_BURST=8 -> beats 1-8 to src0, 1 idle cycle, then 9-16, idle, then 17-20.
//  2. Src1 and src3 request continuously -> grants alternate 8 beats src1, 8 beats src3; src0/2 gnt_o never 1.
//  3. Src2 issues 6 reads, r_valid withheld -> 4 granted, tcdm_req_o=0 after 4th; first r_valid -> 5th issued; rvalid_o[2] x6 in order.
//  4. Reads interleaved: src0 (2) then src1 (2), responses 3 cycles later -> rvalid_o = 0001,0001,0010,0010 in order.
//  5. clear_i with 3 reads outstanding -> busy_o=0 next cycle (no req), later r_valid gives no rvalid_o; next req served from src0.
//  6. PERF_EN: src1 waits 5 cycles then gets 3 beats -> perf stall[1]=5, beats[1]=3.

Source files
------------

// File: rtl/softex_tcdm_sched.sv
// softex_tcdm_sched: round-robin scheduler of N_REQ streamer sources onto one TCDM port with
// burst lock and in-order read-response routing. Define SOFTEX_TCDM_SCHED_PERF_EN to add perf_o.
//
// state | meaning
// IDLE  | no owner; first requester at/after rr pointer is latched (and issued unless just released)
// OWN   | owner latched; port driven from the owner's inputs until release
module softex_tcdm_sched #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ-1:0]            we_i,
  input  logic [N_REQ*ADDR_W-1:0]     addr_i,
  input  logic [N_REQ*DATA_W-1:0]     wdata_i,
  input  logic [N_REQ*DATA_W/8-1:0]   be_i,
  output logic [N_REQ-1:0]            gnt_o,
  output logic [N_REQ-1:0]            rvalid_o,
  output logic [DATA_W-1:0]           rdata_o,
  output logic                        tcdm_req_o,
  input  logic                        tcdm_gnt_i,
  output logic                        tcdm_we_o,
  output logic [ADDR_W-1:0]           tcdm_add_o,
  output logic [DATA_W-1:0]           tcdm_data_o,
  output logic [DATA_W/8-1:0]         tcdm_be_o,
  input  logic                        tcdm_r_valid_i,
  input  logic [DATA_W-1:0]           tcdm_r_data_i,
`ifdef SOFTEX_TCDM_SCHED_PERF_EN
  output logic [N_REQ*2*32-1:0]       perf_o,
`endif
  output logic [$clog2(N_REQ)-1:0]    owner_o,
  output logic                        busy_o
);

  localparam int unsigned IDX_W  = $clog2(N_REQ);
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(MAX_BURST + 1);
  localparam int unsigned PTR_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned OCNT_W = $clog2(MAX_OUTST + 1);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   owner_q, rr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               rel_q;
  logic [IDX_W-1:0]   sel, idx, cur_owner;
  logic               sel_vld, active, rd_block, beat, last_beat, release_own;

  logic [IDX_W-1:0]   fifo_mem [MAX_OUTST];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [OCNT_W-1:0]  fifo_cnt;
  logic               fifo_empty, fifo_full, push, pop;

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(N_REQ - 1)) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] v);
    return (v == PTR_W'(MAX_OUTST - 1)) ? '0 : v + 1'b1;
  endfunction

  // Rotating priority search starting at the RR pointer.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    idx     = rr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (!sel_vld && req_i[idx]) begin
        sel     = idx;
        sel_vld = 1'b1;
      end
      idx = idx_inc(idx);
    end
  end

  // The cycle right after a release (rel_q) only latches the next owner, giving one idle slot.
  assign cur_owner   = (state_q == S_OWN) ? owner_q : sel;
  assign active      = !rst_i && !clear_i && ((state_q == S_OWN) || (sel_vld && !rel_q));
  assign tcdm_we_o   = we_i[cur_owner];
  assign rd_block    = !tcdm_we_o && fifo_full;
  assign tcdm_req_o  = active && req_i[cur_owner] && !rd_block;
  assign tcdm_add_o  = addr_i[cur_owner*ADDR_W +: ADDR_W];
  assign tcdm_data_o = wdata_i[cur_owner*DATA_W +: DATA_W];
  assign tcdm_be_o   = be_i[cur_owner*BE_W +: BE_W];

  assign beat        = tcdm_req_o && tcdm_gnt_i;
  assign last_beat   = beat && (cnt_q == CNT_W'(MAX_BURST - 1));
  assign release_own = last_beat || (!beat && !req_i[owner_q]);
  assign gnt_o       = beat ? (N_REQ'(1) << cur_owner) : '0;

  assign fifo_empty  = (fifo_cnt == '0);
  assign fifo_full   = (fifo_cnt == OCNT_W'(MAX_OUTST));
  assign push        = beat && !tcdm_we_o;
  assign pop         = tcdm_r_valid_i && !fifo_empty && !rst_i && !clear_i;
  assign rvalid_o    = pop ? (N_REQ'(1) << fifo_mem[rd_ptr]) : '0;
  assign rdata_o     = tcdm_r_data_i;
  assign busy_o      = (|req_i) || !fifo_empty;
  assign owner_o     = owner_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      rel_q   <= 1'b0;
    end else begin
      rel_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sel_vld) begin
            owner_q <= sel;
            if (last_beat) begin
              rr_q  <= idx_inc(sel);
              cnt_q <= '0;
              rel_q <= 1'b1;
            end else begin
              state_q <= S_OWN;
              if (beat) cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_OWN: begin
          if (release_own) begin
            state_q <= S_IDLE;
            rr_q    <= idx_inc(owner_q);
            cnt_q   <= '0;
            rel_q   <= 1'b1;
          end else if (beat) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= cur_owner;
  end

`ifdef SOFTEX_TCDM_SCHED_PERF_EN
  // Per source: [2s] granted beats, [2s+1] stall cycles; both saturate.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      perf_o <= '0;
    end else begin
      for (int s = 0; s < N_REQ; s++) begin
        if (gnt_o[s] && (perf_o[2*s*32 +: 32] != '1))
          perf_o[2*s*32 +: 32] <= perf_o[2*s*32 +: 32] + 32'd1;
        if (req_i[s] && !gnt_o[s] && (perf_o[(2*s+1)*32 +: 32] != '1))
          perf_o[(2*s+1)*32 +: 32] <= perf_o[(2*s+1)*32 +: 32] + 32'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  // Responses to reads discarded by clear_i are tolerated; any other orphan response is an error.
  logic [OCNT_W-1:0] stale_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stale_q <= '0;
    end else if (clear_i) begin
      stale_q <= fifo_cnt;
    end else if (tcdm_r_valid_i && fifo_empty) begin
      assert (stale_q != '0) else $error("tcdm_r_valid_i with no outstanding read");
      if (stale_q != '0) stale_q <= stale_q - 1'b1;
    end
  end
`endif

endmodule
